// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: accepts PC fetch requests and returns the 32-bit word stored at that address.
// Latency: LATENCY cycles from request accept to response visible when the response FIFO is empty.
// Backpressure: req_ready drops once FIFO_DEPTH requests are outstanding; a held response stays stable until rsp_ready.
module imem_fetch_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_fault,
    input  logic                  flush,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [31:0]           ld_data
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [31:0]           mem_q [0:(1 << ADDR_WIDTH) - 1];
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  accept;
    logic                  pop;
    logic                  req_fault;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic [31:0]           rd_dat;

    // Data arriving at the response FIFO from the read pipeline.
    logic                  wr_vld;
    logic [31:0]           wr_dat;
    logic                  wr_flt;

    // Response FIFO state.
    logic [31:0]           fd_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] ff_q;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [PW-1:0]         wr_idx;
    logic [CW-1:0]         occ_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The outstanding count covers pipeline and FIFO, so a full count guarantees FIFO space later.
    assign req_ready = (cnt_q < CW'(FIFO_DEPTH));
    assign accept    = req_valid & req_ready;
    // A pop coinciding with flush is meaningless: the head entry is being discarded anyway.
    assign pop       = rsp_valid & rsp_ready & ~flush;
    assign req_idx   = req_addr[ADDR_WIDTH+1:2];
    assign req_fault = (req_addr[1:0] != 2'b00) | ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign rd_dat    = req_fault ? 32'h0 : mem_q[req_idx];

    // Program store write; fetch reads at the same edge see the old word.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    generate
        if (LATENCY <= 1) begin : g_direct
            assign wr_vld = accept;
            assign wr_dat = rd_dat;
            assign wr_flt = req_fault;
        end else begin : g_pipe
            localparam int NS = LATENCY - 1;
            logic [NS-1:0] pv_q;
            logic [31:0]   pd_q [NS];
            logic [NS-1:0] pf_q;

            // Stage valids: stage 0 takes the new accept (it survives flush), older stages die on flush.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pv_q <= '0;
                end else begin
                    pv_q[0] <= accept;
                    for (int i = 1; i < NS; i++) begin
                        pv_q[i] <= pv_q[i-1] & ~flush;
                    end
                end
            end

            // Stage payloads shift unconditionally; validity alone decides whether they matter.
            always_ff @(posedge clk) begin
                pd_q[0] <= rd_dat;
                pf_q[0] <= req_fault;
                for (int i = 1; i < NS; i++) begin
                    pd_q[i] <= pd_q[i-1];
                    pf_q[i] <= pf_q[i-1];
                end
            end

            assign wr_vld = pv_q[NS-1] & ~flush;
            assign wr_dat = pd_q[NS-1];
            assign wr_flt = pf_q[NS-1];
        end
    endgenerate

    // On flush the FIFO restarts at slot 0, so a surviving write lands there.
    assign wr_idx = flush ? '0 : wptr_q;

    // FIFO pointers and occupancy; explicit wrap compare supports non-power-of-two depths.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else if (flush) begin
            rptr_q <= '0;
            wptr_q <= wr_vld ? ptr_inc('0) : '0;
            occ_q  <= wr_vld ? CW'(1) : '0;
        end else begin
            if (wr_vld) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            occ_q <= occ_q + CW'(wr_vld) - CW'(pop);
        end
    end

    // FIFO entry storage.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            fd_q[wr_idx] <= wr_dat;
            ff_q[wr_idx] <= wr_flt;
        end
    end

    // Outstanding-count next state: flush restarts from the redirected fetch, if any.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = accept ? CW'(1) : '0;
        end else if (accept && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !accept) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Outstanding-count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rsp_valid = (occ_q != '0);
    assign rsp_data  = rsp_valid ? fd_q[rptr_q] : 32'h0;
    assign rsp_fault = rsp_valid & ff_q[rptr_q];
endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder for the fetch stage: accepts PC fetch requests and returns the 32-bit instruction word that feeds the fetch stage's prefetch input.
- Word-organised program store with a write/load port, a configurable read pipeline, a response FIFO and flush support for taken branches.
- Sits between the fetch unit (requester) and the program store; the testbench/loader writes programs through the load port.

Parameters:
- ADDR_WIDTH, 10, word-index width; store holds 2^ADDR_WIDTH words.
- LATENCY, 1, request-accept to response-visible delay in cycles; legal 1..4.
- FIFO_DEPTH, 4, response FIFO entries; also the maximum number of outstanding requests.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address (PC) of the fetch.
- rsp_valid  out  1  response word available.
- rsp_ready  in  1  fetch stage consumes the response this cycle.
- rsp_data  out  32  instruction word; 32'h0 on fault.
- rsp_fault  out  1  request was misaligned or out of range.
- flush  in  1  discard all in-flight and queued responses.
- ld_en  in  1  write one word into the store.
- ld_addr  in  ADDR_WIDTH  word index for the load.
- ld_data  in  32  word to store.

Behaviour:
- Reset: synchronous, active-high. rsp_valid=0, rsp_data=0, rsp_fault=0, req_ready=1 the cycle after reset, pipeline and FIFO emptied, outstanding count=0. Store contents are not cleared. Reset mid-transfer drops everything and accepts no request in the reset cycle.
- Accept: at any edge with req_valid & req_ready.
- Handshake rules: req_ready = (outstanding < FIFO_DEPTH), where outstanding = in-pipeline + FIFO occupancy. req_ready does not depend on rsp_ready in the same cycle.
- Index and fault: word index = req_addr[ADDR_WIDTH+1:2].
  - Fault when req_addr[1:0] != 0, or when req_addr[31:ADDR_WIDTH+2] != 0.
  - A faulting request still occupies a slot and returns rsp_data=32'h0 with rsp_fault=1.
- Latency: a request accepted at edge E is readable on rsp_* after edge E+LATENCY-1 when the FIFO is empty. With LATENCY=1 the store is read at E and written straight into the FIFO; each additional cycle of LATENCY adds one register stage. Responses are returned strictly in request order.
- Response handshake: rsp_valid = FIFO not empty. An entry pops at an edge with rsp_valid & rsp_ready. rsp_data and rsp_fault hold stable while rsp_valid=1 and rsp_ready=0.
- Outstanding count:
  - increments on accept; decrements on pop.
  - Simultaneous accept and pop leaves the count unchanged; the FIFO never overflows.
  - The count never wraps below 0 or above FIFO_DEPTH.
- Load port:
  - ld_en writes ld_data at ld_addr on the edge.
  - A read of the same word at the same edge returns the old data (read-before-write).
  - Loads are independent of flush, reset and backpressure.
- Flush:
  - At an edge with flush=1, all pipeline stages and all FIFO entries are invalidated and the count is cleared.
  - A request accepted at the same edge is kept, since it is the redirected fetch; the count becomes 1.
  - A pop in the flush cycle is ignored (the entry is already discarded).
  - rsp_valid=0 after the flush edge until the surviving request emerges.
- FIFO pointers wrap modulo FIFO_DEPTH. FIFO_DEPTH that is not a power of two is supported through explicit wrap compare.

Test Plan:
- Load 0..3 with 32'hC0000004, 32'h11111111, 32'h22222222, 32'h33333333; request addr 0x0,0x4,0x8,0xC back-to-back with rsp_ready=1, LATENCY=1 -> one response per cycle in order, first visible the cycle after the first accept, rsp_fault=0.
- rsp_ready=0 while issuing 6 requests, FIFO_DEPTH=4 -> exactly 4 accepted, req_ready=0 afterwards; release rsp_ready -> 4 words drain in order, req_ready reasserts after the first pop.
- Request 0x6 and then 0x00001000 with ADDR_WIDTH=10 -> two responses with rsp_data=0 and rsp_fault=1; a following request 0x8 returns 32'h22222222 with rsp_fault=0.
- 3 requests in flight with LATENCY=3, then flush together with a new request to 0xC -> the 3 old responses never appear; the only response is 32'h33333333, 3 cycles after the flush edge.
- ld_en writing word 2=32'hDEADBEEF at the same edge a read of 0x8 is accepted -> response 32'h22222222; the next read of 0x8 -> 32'hDEADBEEF.
- reset asserted with the FIFO holding 2 entries -> rsp_valid=0, rsp_data=0 next cycle, req_ready=1; store contents preserved, so a read of 0x4 returns 32'h11111111.
